sel_sequencer: RTL

Upstream driver for the 2-to-4 one-hot decoder: produces the 2-bit select `{s1,s0}` the decoder turns into `y3..y0`. The select advances from two debounced push-buttons (up/down) or free-runs in auto-scan mode, wrapping modulo 4. It also emits a one-cycle `step` strobe whenever the select changes, so downstream logic can latch per-position data.

---
 rtl/sel_sequencer_pkg.sv | 33 +++
 rtl/sel_sequencer_if.sv | 31 +++
 rtl/sel_sequencer_btn_debounce.sv | 57 +++++
 rtl/sel_sequencer.sv | 84 ++++++++
 4 files changed

// File: rtl/sel_sequencer_pkg.sv
// Shared select encoding for the sequencer and the 2-to-4 decoder it drives.
package sel_pkg;

  localparam int unsigned SEL_W = 2;

  typedef logic [SEL_W-1:0] sel_t;

  // Select values; the decoder asserts y<n> for SEL_Y<n>.
  localparam sel_t SEL_Y0 = 2'b00;
  localparam sel_t SEL_Y1 = 2'b01;
  localparam sel_t SEL_Y2 = 2'b10;
  localparam sel_t SEL_Y3 = 2'b11;

  // Action chosen by the up/down/auto arbitration for the current cycle.
  typedef enum logic [1:0] {
    ACT_HOLD = 2'd0,
    ACT_INC  = 2'd1,
    ACT_DEC  = 2'd2
  } sel_act_e;

  // Apply an arbitration action to a select value; wraps modulo 4.
  function automatic sel_t sel_next(input sel_t s, input sel_act_e a);
    sel_t r;
    r = s;
    case (a)
      ACT_INC: r = s + sel_t'(1);
      ACT_DEC: r = s - sel_t'(1);
      default: r = s;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sel_sequencer_if.sv
// Button/mode inputs and select/step outputs of the select sequencer.
interface sel_sequencer_if;

  logic btn_up;
  logic btn_dn;
  logic auto_en;
  logic s1;
  logic s0;
  logic step;

  // Environment side: drives buttons and mode, observes the select.
  modport master (
    output btn_up,
    output btn_dn,
    output auto_en,
    input  s1,
    input  s0,
    input  step
  );

  // Sequencer side.
  modport slave (
    input  btn_up,
    input  btn_dn,
    input  auto_en,
    output s1,
    output s0,
    output step
  );

endinterface

// File: rtl/sel_sequencer_btn_debounce.sv
// One push-button path: 2-FF synchronizer, stability filter, rising-edge press pulse.
module btn_debounce #(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int unsigned CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level_d;
  logic [CW-1:0] cnt;

  // Bring the raw asynchronous button into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // Count consecutive disagreeing cycles; flip the debounced level once the run is long enough.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (sync2 == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      level <= ~level;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Delayed copy of the debounced level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_d <= 1'b0;
    end else begin
      level_d <= level;
    end
  end

  assign press = level & ~level_d;

endmodule

// File: rtl/sel_sequencer.sv
// Select sequencer: debounced up/down buttons or auto-scan drive a 2-bit
// modulo-4 select for the 2-to-4 decoder, with a one-cycle step strobe.
module sel_sequencer
  import sel_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 4,
  parameter int unsigned SCAN_DIV  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  sel_sequencer_if.slave  bus
);

  localparam int unsigned PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

  logic          up_press;
  logic          dn_press;
  logic          up_level_unused;
  logic          dn_level_unused;
  logic [PW-1:0] presc;
  sel_t          sel;
  sel_t          sel_nxt;
  sel_act_e      act;
  logic          step_q;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (bus.btn_up),
    .level (up_level_unused),
    .press (up_press)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dn (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (bus.btn_dn),
    .level (dn_level_unused),
    .press (dn_press)
  );

  // Auto-scan prescaler: held at zero outside auto mode, wraps at SCAN_DIV-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (!bus.auto_en) begin
      presc <= '0;
    end else if (presc == PRE_LAST) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Arbitrate auto-scan versus button presses; presses are dropped in auto mode.
  always_comb begin
    act = ACT_HOLD;
    if (bus.auto_en) begin
      if (presc == PRE_LAST) act = ACT_INC;
    end else if (up_press && !dn_press) begin
      act = ACT_INC;
    end else if (dn_press && !up_press) begin
      act = ACT_DEC;
    end
    sel_nxt = sel_next(sel, act);
  end

  // Select register and change strobe, both straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel    <= SEL_Y0;
      step_q <= 1'b0;
    end else begin
      sel    <= sel_nxt;
      step_q <= (sel_nxt != sel);
    end
  end

  assign bus.s1   = sel[1];
  assign bus.s0   = sel[0];
  assign bus.step = step_q;

endmodule
